// File: rtl/tug_round_ctrl.sv
// Round controller for a two-player tug-of-war light game: key edge detection,
// scoring, post-point display hold, playfield restart and match-over latching.
module tug_round_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned MAX_SCORE   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyL,
  input  logic       keyR,
  input  logic       edgeL,
  input  logic       edgeR,
  output logic       L,
  output logic       R,
  output logic       res,
  output logic [2:0] scoreL,
  output logic [2:0] scoreR,
  output logic [1:0] winner,
  output logic       busy
);

  localparam logic [1:0] StRestart = 2'd0;
  localparam logic [1:0] StPlay    = 2'd1;
  localparam logic [1:0] StHold    = 2'd2;
  localparam logic [1:0] StOver    = 2'd3;

  localparam logic [2:0] MaxScore = 3'(MAX_SCORE);
  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic       keyl_prev_q, keyl_prev_d;
  logic       keyr_prev_q, keyr_prev_d;
  logic       l_q, l_d;
  logic       r_q, r_d;
  logic [2:0] score_l_q, score_l_d;
  logic [2:0] score_r_q, score_r_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic       new_l, new_r;
  logic       point_l, point_r;
  logic [2:0] score_l_inc, score_r_inc;

  always_comb begin
    state_d     = state_q;
    keyl_prev_d = keyL;
    keyr_prev_d = keyR;
    l_d         = 1'b0;
    r_d         = 1'b0;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    hold_cnt_d  = hold_cnt_q;

    new_l   = keyL & ~keyl_prev_q;
    new_r   = keyR & ~keyr_prev_q;
    point_l = (state_q == StPlay) & l_q & edgeL;
    point_r = (state_q == StPlay) & r_q & edgeR;

    // Saturating increment so a count can never wrap back to zero.
    score_l_inc = (score_l_q == 3'd7) ? 3'd7 : score_l_q + 3'd1;
    score_r_inc = (score_r_q == 3'd7) ? 3'd7 : score_r_q + 3'd1;

    case (state_q)
      StRestart: state_d = StPlay;
      StPlay: begin
        if (point_l) begin
          score_l_d = score_l_inc;
          if (score_l_inc == MaxScore) begin
            state_d  = StOver;
            winner_d = 2'b01;
          end else begin
            state_d    = StHold;
            hold_cnt_d = HoldLoad;
          end
        end else if (point_r) begin
          score_r_d = score_r_inc;
          if (score_r_inc == MaxScore) begin
            state_d  = StOver;
            winner_d = 2'b10;
          end else begin
            state_d    = StHold;
            hold_cnt_d = HoldLoad;
          end
        end else begin
          // Simultaneous new presses cancel each other out.
          l_d = new_l & ~new_r;
          r_d = new_r & ~new_l;
        end
      end
      StHold: begin
        if (hold_cnt_q == 8'd0) begin
          state_d = StRestart;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      StOver:  state_d = StOver;
      default: state_d = StRestart;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRestart;
      // Prev registers start high so a key held through reset is not a press.
      keyl_prev_q <= 1'b1;
      keyr_prev_q <= 1'b1;
      l_q         <= 1'b0;
      r_q         <= 1'b0;
      score_l_q   <= 3'd0;
      score_r_q   <= 3'd0;
      winner_q    <= 2'b00;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      keyl_prev_q <= keyl_prev_d;
      keyr_prev_q <= keyr_prev_d;
      l_q         <= l_d;
      r_q         <= r_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign L      = l_q;
  assign R      = r_q;
  assign res    = (state_q == StRestart);
  assign busy   = (state_q != StPlay);
  assign scoreL = score_l_q;
  assign scoreR = score_r_q;
  assign winner = winner_q;

endmodule
